// File: rtl/st_frame_tx_pkg.sv
// Shared definitions for the st_frame_tx serial transmitter: FSM state
// encoding, parity mode constants and a safe counter-width helper.
package st_frame_tx_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // $clog2(1) is 0; never let a counter collapse to zero width
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/st_frame_tx_bit_timer.sv
// Bit-period timer: counts 0..BIT_CYC-1 while enabled and flags the last
// cycle of each serial bit. A restart forces the count back to 0.
module bit_timer
    import st_frame_tx_pkg::*;
#(
    parameter int BIT_CYC = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_restart,
    output logic o_bit_end
);

    localparam int             CNT_W = width_of(BIT_CYC);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_CYC - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_restart) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_bit_end = i_en && (r_cnt == LAST);

endmodule

// File: rtl/st_frame_tx.sv
// Serial frame transmitter: on an accepted start strobe latches a word and
// sends start bit, data LSB first, optional parity bit and stop bit on txd.
module st_frame_tx
    import st_frame_tx_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int BIT_CYC = 434,
    parameter int PARITY  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_st,
    input  logic [DATA_W-1:0] i_din,
    output logic              o_txd,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_ovr
);

    localparam int              IDX_W    = width_of(DATA_W);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_shreg;
    logic [DATA_W-1:0] w_shreg_sh;
    logic [IDX_W-1:0]  r_idx;
    logic              r_par;
    logic              r_txd;
    logic              r_busy;
    logic              r_done;
    logic              r_ovr;
    logic              w_txd_nxt;
    logic              w_done_nxt;
    logic              w_ovr_nxt;
    logic              w_load;
    logic              w_shift;
    logic              w_idx_inc;
    logic              w_bit_end;
    logic              w_timer_en;

    assign w_timer_en = (r_state != S_IDLE);
    assign w_shreg_sh = r_shreg >> 1;

    bit_timer #(
        .BIT_CYC(BIT_CYC)
    ) u_bit_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_en     (w_timer_en),
        .i_restart(w_load),
        .o_bit_end(w_bit_end)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_txd_nxt   = r_txd;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_idx_inc   = 1'b0;
        w_done_nxt  = 1'b0;
        w_ovr_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_txd_nxt = 1'b1;
                if (i_st) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_START;
                    w_txd_nxt   = 1'b0;
                end
            end
            S_START: begin
                w_ovr_nxt = i_st;
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                    w_txd_nxt   = r_shreg[0];
                end
            end
            S_DATA: begin
                w_ovr_nxt = i_st;
                if (w_bit_end) begin
                    if (r_idx == IDX_LAST) begin
                        if (PARITY != PAR_NONE) begin
                            w_state_nxt = S_PAR;
                            w_txd_nxt   = r_par;
                        end else begin
                            w_state_nxt = S_STOP;
                            w_txd_nxt   = 1'b1;
                        end
                    end else begin
                        w_shift   = 1'b1;
                        w_idx_inc = 1'b1;
                        w_txd_nxt = w_shreg_sh[0];
                    end
                end
            end
            S_PAR: begin
                w_ovr_nxt = i_st;
                if (w_bit_end) begin
                    w_state_nxt = S_STOP;
                    w_txd_nxt   = 1'b1;
                end
            end
            S_STOP: begin
                // A strobe on the final stop cycle chains the next frame with no gap
                if (w_bit_end) begin
                    w_done_nxt = 1'b1;
                    if (i_st) begin
                        w_load      = 1'b1;
                        w_state_nxt = S_START;
                        w_txd_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_txd_nxt   = 1'b1;
                    end
                end else begin
                    w_ovr_nxt = i_st;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_txd_nxt   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_txd   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_txd   <= w_txd_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= w_done_nxt;
            r_ovr   <= w_ovr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg <= '0;
            r_par   <= 1'b0;
            r_idx   <= '0;
        end else if (w_load) begin
            r_shreg <= i_din;
            r_par   <= (PARITY == PAR_ODD) ? ~^i_din : ^i_din;
            r_idx   <= '0;
        end else begin
            if (w_shift)   r_shreg <= w_shreg_sh;
            if (w_idx_inc) r_idx   <= r_idx + 1'b1;
        end
    end

    assign o_txd  = r_txd;
    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_ovr  = r_ovr;

endmodule

// File: tb/tb_st_frame_tx.sv
// Bench for st_frame_tx: three instances (no/even/odd parity) share the same
// stimulus and are checked every cycle against a frame-position model.
module tb_st_frame_tx;

    localparam int BC = 4;
    localparam int DW = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       st;
    logic [7:0] din;
    logic       txd  [3];
    logic       busy [3];
    logic       done [3];
    logic       ovr  [3];

    int         total = 0;
    int         bad   = 0;

    int         pos      [3];
    logic [7:0] word     [3];
    logic       exp_done [3];
    logic       exp_ovr  [3];

    always #10 clk = ~clk;

    st_frame_tx #(.DATA_W(DW), .BIT_CYC(BC), .PARITY(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .i_st(st), .i_din(din),
        .o_txd(txd[0]), .o_busy(busy[0]), .o_done(done[0]), .o_ovr(ovr[0]));
    st_frame_tx #(.DATA_W(DW), .BIT_CYC(BC), .PARITY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i_st(st), .i_din(din),
        .o_txd(txd[1]), .o_busy(busy[1]), .o_done(done[1]), .o_ovr(ovr[1]));
    st_frame_tx #(.DATA_W(DW), .BIT_CYC(BC), .PARITY(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .i_st(st), .i_din(din),
        .o_txd(txd[2]), .o_busy(busy[2]), .o_done(done[2]), .o_ovr(ovr[2]));

    function automatic int flen(input int p);
        return (2 + DW + ((p != 0) ? 1 : 0)) * BC;
    endfunction

    // Expected line level from the position inside the frame (pos<0 = idle)
    function automatic logic exp_txd(input int p);
        int b;
        if (pos[p] < 0) return 1'b1;
        b = pos[p] / BC;
        if (b == 0) return 1'b0;
        if (b <= DW) return word[p][b-1];
        if (p != 0 && b == DW + 1) return (p == 1) ? ^word[p] : ~^word[p];
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic obs, input logic expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < 3; p++) begin
            pos[p]      = -1;
            exp_done[p] = 1'b0;
            exp_ovr[p]  = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        for (int p = 0; p < 3; p++) begin
            check($sformatf("%s_txd%0d", tag, p),  txd[p],  exp_txd(p));
            check($sformatf("%s_busy%0d", tag, p), busy[p], (pos[p] >= 0));
            check($sformatf("%s_done%0d", tag, p), done[p], exp_done[p]);
            check($sformatf("%s_ovr%0d", tag, p),  ovr[p],  exp_ovr[p]);
        end
    endtask

    task automatic step(input string tag, input logic s, input logic [7:0] d);
        logic idle, last;
        st  = s;
        din = d;
        @(posedge clk);
        for (int p = 0; p < 3; p++) begin
            idle        = (pos[p] < 0);
            last        = (pos[p] == flen(p) - 1);
            exp_done[p] = last;
            exp_ovr[p]  = s && !idle && !last;
            if (s && (idle || last)) begin
                pos[p]  = 0;
                word[p] = d;
            end else if (last) begin
                pos[p] = -1;
            end else if (!idle) begin
                pos[p] = pos[p] + 1;
            end
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        int nb, nd, no;
        rst_n = 1'b0;
        st    = 1'b0;
        din   = 8'h00;
        model_reset();

        // 1: reset values, then release with st low
        #100;
        for (int p = 0; p < 3; p++) begin
            check($sformatf("rst_txd%0d", p),  txd[p],  1'b1);
            check($sformatf("rst_busy%0d", p), busy[p], 1'b0);
            check($sformatf("rst_done%0d", p), done[p], 1'b0);
            check($sformatf("rst_ovr%0d", p),  ovr[p],  1'b0);
        end
        rst_n = 1'b1;
        repeat (3) step("idle", 1'b0, 8'h00);

        // 2: A5 without parity, 40 busy cycles and a single done
        nb = 0; nd = 0;
        for (int i = 1; i <= 46; i++) begin
            step("t2", (i == 1), (i == 1) ? 8'hA5 : 8'h5A);
            if (busy[0]) nb++;
            if (done[0]) nd++;
        end
        check_int("t2_busy_cycles", nb, 40);
        check_int("t2_done_pulses", nd, 1);

        // 3: 07 with even/odd parity, 44-cycle frames
        nb = 0;
        for (int i = 1; i <= 48; i++) begin
            step("t3", (i == 1), (i == 1) ? 8'h07 : 8'hFF);
            if (busy[1]) nb++;
            if (i == 37) begin
                check("t3_par_even", txd[1], 1'b1);
                check("t3_par_odd",  txd[2], 1'b0);
            end
        end
        check_int("t3_busy_cycles_par", nb, 44);

        // 4: second strobe 10 cycles into a frame
        nb = 0; no = 0;
        for (int i = 1; i <= 48; i++) begin
            step("t4", (i == 1) || (i == 11), (i == 1) ? 8'hA5 : 8'h00);
            if (busy[0]) nb++;
            if (ovr[0])  no++;
        end
        check_int("t4_ovr_pulses", no, 1);
        check_int("t4_busy_cycles", nb, 40);

        // 5: strobe on the last stop cycle chains frames with no gap
        nb = 0; nd = 0;
        for (int i = 1; i <= 81; i++) begin
            step("t5", (i == 1) || (i == 41), (i == 1) ? 8'hA5 : 8'h3C);
            if (busy[0] && i <= 80) nb++;
            if (done[0]) nd++;
            if (i == 81) check("t5_idle_after", busy[0], 1'b0);
        end
        check_int("t5_busy_cycles", nb, 80);
        check_int("t5_done_pulses", nd, 2);
        repeat (10) step("t5w", 1'b0, 8'h00);

        // 6: reset during data bit 3, then a clean FF frame
        step("t6", 1'b1, 8'h5A);
        repeat (17) step("t6", 1'b0, 8'h00);
        #3 rst_n = 1'b0;
        #1;
        for (int p = 0; p < 3; p++) begin
            check($sformatf("t6_rst_txd%0d", p),  txd[p],  1'b1);
            check($sformatf("t6_rst_busy%0d", p), busy[p], 1'b0);
        end
        model_reset();
        #20 rst_n = 1'b1;
        nb = 0;
        for (int i = 1; i <= 46; i++) begin
            step("t6b", (i == 1), 8'hFF);
            if (busy[0]) nb++;
        end
        check_int("t6_busy_cycles", nb, 40);

        // Random strobes and words
        for (int i = 0; i < 600; i++)
            step("rnd", ($urandom_range(0, 15) == 0), 8'($urandom));

        // Strobe held high: continuous back-to-back frames
        nd = 0;
        for (int i = 0; i < 130; i++) begin
            step("hold", 1'b1, 8'($urandom));
            if (done[0]) nd++;
        end
        check_int("hold_done_pulses", nd, 3);
        repeat (50) step("tail", 1'b0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
